// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and default widths for the convolution MAC blocks.
package conv_pkg;

   // MAC sequencing states: accumulate beats, let the last product land, present result
   typedef enum logic [1:0] {
      MAC_ACC   = 2'd0,
      MAC_DRAIN = 2'd1,
      MAC_OUT   = 2'd2
   } mac_state_e;

   localparam int CONV_TAPS   = 9;
   localparam int CONV_DWIDTH = 8;
   localparam int CONV_WWIDTH = 8;
   localparam int CONV_AWIDTH = 32;

endpackage

// File: rtl/conv_mac_serial_if.sv
// conv_mac_serial_if: pixel/weight FIFO read ports plus the window result handshake.
// The master side is the MAC stage; the slave side is the FIFOs and the result consumer.
interface conv_mac_serial_if
   import conv_pkg::*;
   #(
      parameter int DWIDTH = CONV_DWIDTH,
      parameter int WWIDTH = CONV_WWIDTH,
      parameter int AWIDTH = CONV_AWIDTH
   );

   logic              i_pix_empty;
   logic              o_pix_deq;
   logic [DWIDTH-1:0] i_pix_data;
   logic              i_wgt_empty;
   logic              o_wgt_deq;
   logic [WWIDTH-1:0] i_wgt_data;
   logic              o_res_valid;
   logic              i_res_ready;
   logic [AWIDTH-1:0] o_res_data;

   modport master (
      input  i_pix_empty, i_pix_data, i_wgt_empty, i_wgt_data, i_res_ready,
      output o_pix_deq, o_wgt_deq, o_res_valid, o_res_data
   );

   modport slave (
      output i_pix_empty, i_pix_data, i_wgt_empty, i_wgt_data, i_res_ready,
      input  o_pix_deq, o_wgt_deq, o_res_valid, o_res_data
   );

endinterface

// File: rtl/conv_mul_pipe.sv
// conv_mul_pipe: one registered signed multiply, sign-extended to the accumulator
// width, with a valid bit travelling alongside. Shared with the parallel MAC.
module conv_mul_pipe
   import conv_pkg::*;
   #(
      parameter int DWIDTH = CONV_DWIDTH,
      parameter int WWIDTH = CONV_WWIDTH,
      parameter int AWIDTH = CONV_AWIDTH
   )
   (
      input  logic              i_clk,
      input  logic              i_rst_n,
      input  logic              i_valid,
      input  logic [DWIDTH-1:0] i_a,
      input  logic [WWIDTH-1:0] i_b,
      output logic [AWIDTH-1:0] o_prod,
      output logic              o_valid
   );

   logic signed [AWIDTH-1:0] a_ext;
   logic signed [AWIDTH-1:0] b_ext;
   logic signed [AWIDTH-1:0] prod_ext;

   // Widening both operands first keeps the product exact, since AWIDTH >= DWIDTH+WWIDTH
   assign a_ext    = AWIDTH'($signed(i_a));
   assign b_ext    = AWIDTH'($signed(i_b));
   assign prod_ext = a_ext * b_ext;

   // Capture the product only on a valid beat; the valid flag follows every cycle
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_prod  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) begin
            o_prod <= prod_ext;
         end
      end
   end

endmodule

// File: rtl/conv_mac_serial.sv
// conv_mac_serial: pops one pixel/weight pair per beat from two FIFOs, multiplies in
// stage 1, accumulates in stage 2, and offers each TAPS-long window sum on valid/ready.
module conv_mac_serial
   import conv_pkg::*;
   #(
      parameter int TAPS   = CONV_TAPS,
      parameter int DWIDTH = CONV_DWIDTH,
      parameter int WWIDTH = CONV_WWIDTH,
      parameter int AWIDTH = CONV_AWIDTH
   )
   (
      input  logic               i_clk,
      input  logic               i_rst_n,
      conv_mac_serial_if.master  bus,
      output logic               o_busy
   );

   localparam int            CW       = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

   mac_state_e        state;
   logic [CW-1:0]     tap_cnt;
   logic [AWIDTH-1:0] acc;
   logic [AWIDTH-1:0] acc_next;
   logic [AWIDTH-1:0] prod_r;
   logic              prod_v;
   logic              beat;
   logic              res_valid;
   logic [AWIDTH-1:0] res_data;

   // A beat needs both FIFOs non-empty so the two streams never drift apart;
   // gating with reset keeps the dequeues quiet while reset is held
   assign beat          = i_rst_n && (state == MAC_ACC) && !bus.i_pix_empty && !bus.i_wgt_empty;
   assign bus.o_pix_deq = beat;
   assign bus.o_wgt_deq = beat;

   assign acc_next    = prod_v ? (acc + prod_r) : acc;
   assign o_busy      = (state != MAC_ACC) || (tap_cnt != '0);

   assign bus.o_res_valid = res_valid;
   assign bus.o_res_data  = res_data;

   conv_mul_pipe #(
      .DWIDTH (DWIDTH),
      .WWIDTH (WWIDTH),
      .AWIDTH (AWIDTH)
   ) u_mul (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (beat),
      .i_a     (bus.i_pix_data),
      .i_b     (bus.i_wgt_data),
      .o_prod  (prod_r),
      .o_valid (prod_v)
   );

   // Window sequencer: count taps, let the final product drain into acc, then hold the result until accepted
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= MAC_ACC;
         tap_cnt   <= '0;
         acc       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         case (state)
            MAC_ACC: begin
               acc <= acc_next;
               if (beat) begin
                  if (tap_cnt == LAST_TAP) begin
                     tap_cnt <= '0;
                     state   <= MAC_DRAIN;
                  end else begin
                     tap_cnt <= tap_cnt + CW'(1);
                  end
               end
            end
            MAC_DRAIN: begin
               acc       <= acc_next;
               res_data  <= acc_next;
               res_valid <= 1'b1;
               state     <= MAC_OUT;
            end
            MAC_OUT: begin
               if (bus.i_res_ready) begin
                  acc       <= '0;
                  tap_cnt   <= '0;
                  res_valid <= 1'b0;
                  state     <= MAC_ACC;
               end
            end
            default: begin
               state <= MAC_ACC;
            end
         endcase
      end
   end

endmodule
